// File: rtl/lock_entry_sequencer_if.sv
// Keypad lock sequencer bus: encoded keys and strobes in, lock/alarm status out.
// master drives the key/strobe side, slave is the sequencer.
interface lock_entry_sequencer_if;
    logic [4:0] key_in;
    logic       enter;
    logic       clear;
    logic       alarm_reset;
    logic       prog;
    logic       unlocked;
    logic       alarm;
    logic       error;
    logic [3:0] attempts;
    logic [3:0] digit_count;

    modport master (
        output key_in, enter, clear, alarm_reset, prog,
        input  unlocked, alarm, error, attempts, digit_count
    );

    modport slave (
        input  key_in, enter, clear, alarm_reset, prog,
        output unlocked, alarm, error, attempts, digit_count
    );
endinterface

// File: rtl/lock_entry_sequencer.sv
// Keypad lock entry FSM: digit capture, code check, unlock window, alarm.
// Optional code reprogramming while unlocked when LOCK_REPROGRAM_EN is defined.
module lock_entry_sequencer #(
    parameter int DIGITS = 4,
    parameter int MAX_ATTEMPTS = 3,
    parameter int UNLOCK_CYCLES = 16,
    parameter logic [4*DIGITS-1:0] DEFAULT_CODE = 16'h1234
) (
    input logic clk,
    input logic rst,
    lock_entry_sequencer_if.slave bus
);

    localparam int W = 4 * DIGITS;
    localparam int TW = (UNLOCK_CYCLES > 1) ? $clog2(UNLOCK_CYCLES) : 1;

`ifdef LOCK_REPROGRAM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_ENTRY, S_CHECK, S_UNLOCKED, S_ALARM, S_PROGRAM
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_ENTRY, S_CHECK, S_UNLOCKED, S_ALARM
    } state_t;
`endif

    state_t state_q, state_n;
    logic [W-1:0] entry_q, entry_n;
    logic [3:0] count_q, count_n;
    logic [3:0] attempts_q, attempts_n;
    logic [TW-1:0] timer_q, timer_n;
    logic unlocked_q, unlocked_n;
    logic alarm_q, alarm_n;
    logic error_q, error_n;
    logic key_prev_q;
    logic [W-1:0] code;

    logic [3:0] digit;
    logic press;
    logic accept;
    logic full;
    logic [W-1:0] shifted;

    assign digit = bus.key_in[3:0];
    assign press = bus.key_in[4] & ~key_prev_q;
    assign full = (count_q == 4'(DIGITS));
    assign accept = press && (digit <= 4'd9) && !full;
    assign shifted = (entry_q << 4) | W'(digit);

`ifdef LOCK_REPROGRAM_EN
    logic [W-1:0] code_n;

    // Stored code: reloads the default on reset, written on a full commit.
    always_ff @(posedge clk) begin
        if (rst) code <= DEFAULT_CODE;
        else     code <= code_n;
    end
`else
    logic unused_prog;
    assign unused_prog = bus.prog;
    assign code = DEFAULT_CODE;
`endif

    // State and datapath registers; key_prev starts high to mask held keys.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            entry_q    <= '0;
            count_q    <= '0;
            attempts_q <= '0;
            timer_q    <= '0;
            unlocked_q <= 1'b0;
            alarm_q    <= 1'b0;
            error_q    <= 1'b0;
            key_prev_q <= 1'b1;
        end else begin
            state_q    <= state_n;
            entry_q    <= entry_n;
            count_q    <= count_n;
            attempts_q <= attempts_n;
            timer_q    <= timer_n;
            unlocked_q <= unlocked_n;
            alarm_q    <= alarm_n;
            error_q    <= error_n;
            key_prev_q <= bus.key_in[4];
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_n    = state_q;
        entry_n    = entry_q;
        count_n    = count_q;
        attempts_n = attempts_q;
        timer_n    = timer_q;
        unlocked_n = unlocked_q;
        alarm_n    = alarm_q;
        error_n    = 1'b0;
`ifdef LOCK_REPROGRAM_EN
        code_n     = code;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    entry_n = W'(digit);
                    count_n = 4'd1;
                    state_n = S_ENTRY;
                end
            end
            S_ENTRY: begin
                if (bus.clear) begin
                    entry_n = '0;
                    count_n = '0;
                    state_n = S_IDLE;
                end else if (bus.enter) begin
                    state_n = S_CHECK;
                    if (full && entry_q == code) begin
                        unlocked_n = 1'b1;
                        timer_n    = TW'(UNLOCK_CYCLES - 1);
                        attempts_n = '0;
                    end else begin
                        error_n    = 1'b1;
                        attempts_n = attempts_q + 4'd1;
                    end
                end else if (accept) begin
                    entry_n = shifted;
                    count_n = count_q + 4'd1;
                end
            end
            S_CHECK: begin
                entry_n = '0;
                count_n = '0;
                if (unlocked_q) begin
                    if (timer_q == '0) begin
                        unlocked_n = 1'b0;
                        state_n    = S_IDLE;
                    end else begin
                        timer_n = timer_q - TW'(1);
                        state_n = S_UNLOCKED;
                    end
                end else if (attempts_q == 4'(MAX_ATTEMPTS)) begin
                    alarm_n = 1'b1;
                    state_n = S_ALARM;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_UNLOCKED: begin
                if (bus.clear) begin
                    unlocked_n = 1'b0;
                    state_n    = S_IDLE;
`ifdef LOCK_REPROGRAM_EN
                end else if (bus.prog) begin
                    entry_n = '0;
                    count_n = '0;
                    state_n = S_PROGRAM;
`endif
                end else if (timer_q == '0) begin
                    unlocked_n = 1'b0;
                    state_n    = S_IDLE;
                end else begin
                    timer_n = timer_q - TW'(1);
                end
            end
            S_ALARM: begin
                if (bus.alarm_reset) begin
                    alarm_n    = 1'b0;
                    attempts_n = '0;
                    state_n    = S_IDLE;
                end
            end
`ifdef LOCK_REPROGRAM_EN
            S_PROGRAM: begin
                if (bus.clear || bus.enter) begin
                    if (!bus.clear && full) code_n = entry_q;
                    entry_n    = '0;
                    count_n    = '0;
                    unlocked_n = 1'b0;
                    state_n    = S_IDLE;
                end else if (accept) begin
                    entry_n = shifted;
                    count_n = count_q + 4'd1;
                end
            end
`endif
            default: state_n = S_IDLE;
        endcase
    end

    assign bus.unlocked    = unlocked_q;
    assign bus.alarm       = alarm_q;
    assign bus.error       = error_q;
    assign bus.attempts    = attempts_q;
    assign bus.digit_count = count_q;

endmodule

// File: tb/tb_lock_entry_sequencer.sv
// Directed vector bench for lock_entry_sequencer.
// Covers the default build and the LOCK_REPROGRAM_EN build.
module tb_lock_entry_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lock_entry_sequencer_if bus ();

    lock_entry_sequencer dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [4:0] key;
        logic en;
        logic cl;
        logic ar;
        logic u;
        logic a;
        logic e;
        logic [3:0] att;
        logic [3:0] dc;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int failures = 0;

    function automatic void add(input logic [4:0] k, input logic en,
                                input logic cl, input logic ar,
                                input logic u, input logic a, input logic e,
                                input logic [3:0] att, input logic [3:0] dc);
        vec_t v;
        v.key = k; v.en = en; v.cl = cl; v.ar = ar;
        v.u = u; v.a = a; v.e = e; v.att = att; v.dc = dc;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic u, input logic a,
                           input logic e, input logic [3:0] att,
                           input logic [3:0] dc);
        chk({nm, ".unlocked"}, 32'(bus.unlocked), 32'(u));
        chk({nm, ".alarm"}, 32'(bus.alarm), 32'(a));
        chk({nm, ".error"}, 32'(bus.error), 32'(e));
        chk({nm, ".attempts"}, 32'(bus.attempts), 32'(att));
        chk({nm, ".digit_count"}, 32'(bus.digit_count), 32'(dc));
    endtask

    task automatic step(input logic [4:0] k, input logic en, input logic cl,
                        input logic ar, input logic pg);
        @(negedge clk);
        bus.key_in = k;
        bus.enter = en;
        bus.clear = cl;
        bus.alarm_reset = ar;
        bus.prog = pg;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(5'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic press(input int d);
        step(5'(16 + d), 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
    endtask

    task automatic enter_code(input int a, input int b, input int c,
                              input int d);
        press(a); press(b); press(c); press(d);
        step(5'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    int cnt;
    logic err_seen;

    initial begin
        bus.key_in = '0;
        bus.enter = 1'b0;
        bus.clear = 1'b0;
        bus.alarm_reset = 1'b0;
        bus.prog = 1'b0;

        // alarm build-up and alarm reset
        add(5'h11, 0, 0, 0, 0, 0, 0, 0, 1);
        add(5'h12, 0, 0, 0, 0, 0, 0, 0, 2);
        add(5'h13, 0, 0, 0, 0, 0, 0, 0, 3);
        add(5'h15, 0, 0, 0, 0, 0, 0, 0, 4);
        add(5'h00, 1, 0, 0, 0, 0, 1, 1, 4);
        add(5'h11, 0, 0, 0, 0, 0, 0, 1, 1);
        add(5'h12, 0, 0, 0, 0, 0, 0, 1, 2);
        add(5'h13, 0, 0, 0, 0, 0, 0, 1, 3);
        add(5'h15, 0, 0, 0, 0, 0, 0, 1, 4);
        add(5'h00, 1, 0, 0, 0, 0, 1, 2, 4);
        add(5'h11, 0, 0, 0, 0, 0, 0, 2, 1);
        add(5'h12, 0, 0, 0, 0, 0, 0, 2, 2);
        add(5'h13, 0, 0, 0, 0, 0, 0, 2, 3);
        add(5'h15, 0, 0, 0, 0, 0, 0, 2, 4);
        add(5'h00, 1, 0, 0, 0, 0, 1, 3, 4);
        add(5'h11, 0, 0, 0, 0, 1, 0, 3, 0);
        add(5'h12, 0, 0, 0, 0, 1, 0, 3, 0);
        add(5'h13, 0, 0, 0, 0, 1, 0, 3, 0);
        add(5'h14, 0, 0, 0, 0, 1, 0, 3, 0);
        add(5'h00, 1, 0, 0, 0, 1, 0, 3, 0);
        add(5'h00, 0, 1, 0, 0, 1, 0, 3, 0);
        add(5'h00, 0, 0, 1, 0, 0, 0, 0, 0);
        add(5'h11, 0, 0, 0, 0, 0, 0, 0, 1);
        add(5'h12, 0, 0, 0, 0, 0, 0, 0, 2);
        add(5'h13, 0, 0, 0, 0, 0, 0, 0, 3);
        add(5'h14, 0, 0, 0, 0, 0, 0, 0, 4);
        add(5'h00, 1, 0, 0, 1, 0, 0, 0, 4);
        add(5'h15, 0, 0, 0, 1, 0, 0, 0, 0);
        add(5'h00, 0, 1, 0, 0, 0, 0, 0, 0);
        // short entry, invalid digit, overflow digit
        add(5'h1A, 0, 0, 0, 0, 0, 0, 0, 0);
        add(5'h11, 0, 0, 0, 0, 0, 0, 0, 1);
        add(5'h12, 0, 0, 0, 0, 0, 0, 0, 2);
        add(5'h00, 1, 0, 0, 0, 0, 1, 1, 2);
        add(5'h11, 0, 0, 0, 0, 0, 0, 1, 1);
        add(5'h12, 0, 0, 0, 0, 0, 0, 1, 2);
        add(5'h13, 0, 0, 0, 0, 0, 0, 1, 3);
        add(5'h14, 0, 0, 0, 0, 0, 0, 1, 4);
        add(5'h15, 0, 0, 0, 0, 0, 0, 1, 4);
        add(5'h00, 1, 0, 0, 1, 0, 0, 0, 4);
        add(5'h00, 0, 1, 0, 0, 0, 0, 0, 0);
        // clear mid-entry, enter beats a same-cycle key
        add(5'h11, 0, 0, 0, 0, 0, 0, 0, 1);
        add(5'h19, 0, 0, 0, 0, 0, 0, 0, 2);
        add(5'h00, 0, 1, 0, 0, 0, 0, 0, 0);
        add(5'h11, 0, 0, 0, 0, 0, 0, 0, 1);
        add(5'h12, 0, 0, 0, 0, 0, 0, 0, 2);
        add(5'h13, 0, 0, 0, 0, 0, 0, 0, 3);
        add(5'h14, 0, 0, 0, 0, 0, 0, 0, 4);
        add(5'h00, 1, 0, 0, 1, 0, 0, 0, 4);
        add(5'h00, 0, 1, 0, 0, 0, 0, 0, 0);
        add(5'h11, 0, 0, 0, 0, 0, 0, 0, 1);
        add(5'h12, 1, 0, 0, 0, 0, 1, 1, 1);
        add(5'h00, 0, 0, 0, 0, 0, 0, 1, 0);
        add(5'h00, 1, 0, 0, 0, 0, 0, 1, 0);

        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        // unlock window length
        enter_code(1, 2, 3, 4);
        cnt = 0;
        err_seen = bus.error;
        if (bus.unlocked) cnt++;
        for (int i = 0; i < 40 && bus.unlocked; i++) begin
            idle();
            if (bus.unlocked) cnt++;
            err_seen |= bus.error;
        end
        chk("unlock_len", 32'(cnt), 32'd16);
        chk("unlock_err", 32'(err_seen), 32'd0);
        chk("unlock_att", 32'(bus.attempts), 32'd0);

        foreach (vecs[i]) begin
            step(vecs[i].key, vecs[i].en, vecs[i].cl, vecs[i].ar, 1'b0);
            chk_out($sformatf("vec%0d", i), vecs[i].u, vecs[i].a,
                    vecs[i].e, vecs[i].att, vecs[i].dc);
            idle();
        end

        // key held through reset is not a press
        @(negedge clk);
        rst = 1'b1;
        bus.key_in = 5'h11;
        @(posedge clk);
        #1;
        chk_out("rst_mid", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("held_key_dc", 32'(bus.digit_count), 32'd0);
        idle();
        chk("release_dc", 32'(bus.digit_count), 32'd0);
        press(1);
        chk("repress_dc", 32'(bus.digit_count), 32'd1);
        press(2);
        press(3);
        chk("entry3_dc", 32'(bus.digit_count), 32'd3);
        do_reset();
        #1;
        chk("rst_entry_dc", 32'(bus.digit_count), 32'd0);
        press(7);
        chk("after_rst_idle", 32'(bus.digit_count), 32'd1);
        step(5'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("clear_dc", 32'(bus.digit_count), 32'd0);

`ifdef LOCK_REPROGRAM_EN
        enter_code(1, 2, 3, 4);
        chk("rp_unlock", 32'(bus.unlocked), 32'd1);
        idle();
        step(5'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rp_prog_unl", 32'(bus.unlocked), 32'd1);
        press(5); press(6); press(7); press(8);
        chk("rp_dc", 32'(bus.digit_count), 32'd4);
        step(5'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rp_commit_unl", 32'(bus.unlocked), 32'd0);
        idle();
        enter_code(1, 2, 3, 4);
        chk("rp_old_err", 32'(bus.error), 32'd1);
        chk("rp_old_unl", 32'(bus.unlocked), 32'd0);
        idle();
        enter_code(5, 6, 7, 8);
        chk("rp_new_unl", 32'(bus.unlocked), 32'd1);
        chk("rp_new_att", 32'(bus.attempts), 32'd0);
        idle();
        step(5'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        do_reset();
        enter_code(1, 2, 3, 4);
        chk("rp_rst_code", 32'(bus.unlocked), 32'd1);
        idle();
        step(5'h00, 1'b0, 1'b1, 1'b0, 1'b0);
`else
        enter_code(1, 2, 3, 4);
        idle();
        step(5'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        press(5);
        chk("prog_ign_unl", 32'(bus.unlocked), 32'd1);
        chk("prog_ign_dc", 32'(bus.digit_count), 32'd0);
        step(5'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("prog_ign_clr", 32'(bus.unlocked), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
